// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the committed-store buffer.
// Entry layout keeps the word address separate from the byte mask so lookups compare words only.
package store_buffer_pkg;

    localparam int SB_XLEN          = 32;
    localparam int SB_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic                 valid;
        logic [SB_XLEN-3:0]   waddr;
        logic [3:0]           wmask;
        logic [SB_XLEN-1:0]   data;
    } sb_entry_t;

    function automatic logic [SB_XLEN-3:0] word_addr(input logic [SB_XLEN-1:0] addr);
        return addr[SB_XLEN-1:2];
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store, drain and load-lookup signal bundle of the store buffer.
// slave: the buffer itself; master: the surrounding pipeline (or a bench).
interface store_buffer_if #(
    parameter int XLEN = 32
);
    logic            st_valid;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_data;
    logic [2:0]      st_funct3;
    logic            st_accept;

    logic            dmem_req_valid;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_wmask;
    logic            dmem_req_rdy;

    logic            ld_valid;
    logic [XLEN-1:0] ld_addr;
    logic [2:0]      ld_funct3;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
    logic            ld_conflict;

    logic            sb_empty;
    logic            misalign_err;

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3, dmem_req_rdy,
               ld_valid, ld_addr, ld_funct3,
        output st_accept, dmem_req_valid, dmem_addr, dmem_wdata, dmem_wmask,
               fwd_hit, fwd_data, ld_conflict, sb_empty, misalign_err
    );

    modport master (
        output st_valid, st_addr, st_data, st_funct3, dmem_req_rdy,
               ld_valid, ld_addr, ld_funct3,
        input  st_accept, dmem_req_valid, dmem_addr, dmem_wdata, dmem_wmask,
               fwd_hit, fwd_data, ld_conflict, sb_empty, misalign_err
    );
endinterface

// File: rtl/store_buffer_lane_align.sv
// store_lane_align: maps access size + addr[1:0] to byte mask, lane-replicated data, misaligned flag.
// Purely combinational; shared by the store write path and the load byte-need path.
module store_lane_align
    import store_buffer_pkg::*;
(
    input  logic [1:0]         size,
    input  logic [1:0]         addr_lo,
    input  logic [SB_XLEN-1:0] data,
    output logic [3:0]         mask,
    output logic [SB_XLEN-1:0] shifted,
    output logic               misaligned
);
    // Shifting inside a 4-bit result drops lanes past byte 3 on misaligned halves.
    always_comb begin
        mask       = 4'b0000;
        shifted    = data;
        misaligned = 1'b0;
        case (mem_size_e'(size))
            SZ_BYTE: begin
                mask    = 4'b0001 << addr_lo;
                shifted = {4{data[7:0]}};
            end
            SZ_HALF: begin
                mask       = 4'b0011 << addr_lo;
                shifted    = {2{data[15:0]}};
                misaligned = addr_lo[0];
            end
            SZ_WORD: begin
                mask       = 4'hF;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/store_buffer.sv
// Committed-store FIFO: queues stores in order, drains one per cycle to D$, forwards to loads.
// Latency: store visible to lookup/drain the cycle after accept; lookup is same-cycle combinational.
// Backpressure: st_accept drops only when full; head request holds while dmem_req_rdy is low. Option: SB_FWD_EN.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int SB_DEPTH = SB_DEPTH_DEFAULT,
    parameter int XLEN     = SB_XLEN
)(
    input  logic           clk,
    input  logic           rst,
    store_buffer_if.slave  sb
);
    localparam int PW = $clog2(SB_DEPTH);

    sb_entry_t       entries [SB_DEPTH];
    logic [PW-1:0]   head, tail;
    logic [PW:0]     count;
    logic            misalign_q;

    logic [3:0]      st_mask, ld_need;
    logic [XLEN-1:0] st_shifted, ld_shifted_unused;
    logic            st_misaligned, ld_misaligned_unused;
    logic            push, pop, req_valid;

    store_lane_align u_st_align (
        .size(sb.st_funct3[1:0]), .addr_lo(sb.st_addr[1:0]), .data(sb.st_data),
        .mask(st_mask), .shifted(st_shifted), .misaligned(st_misaligned)
    );

    store_lane_align u_ld_align (
        .size(sb.ld_funct3[1:0]), .addr_lo(sb.ld_addr[1:0]), .data('0),
        .mask(ld_need), .shifted(ld_shifted_unused), .misaligned(ld_misaligned_unused)
    );

    // Fullness uses the registered count only, so D$ readiness never reaches st_accept.
    assign push      = !rst && sb.st_valid && (count != (PW+1)'(SB_DEPTH));
    assign req_valid = (count != '0);
    assign pop       = req_valid && sb.dmem_req_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < SB_DEPTH; i++) entries[i] <= '0;
        end else begin
            if (push) begin
                entries[tail] <= '{valid: 1'b1, waddr: word_addr(sb.st_addr),
                                   wmask: st_mask, data: st_shifted};
                tail <= tail + 1'b1;
                if (st_misaligned) misalign_q <= 1'b1;
            end
            if (pop) begin
                entries[head].valid <= 1'b0;
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign sb.st_accept      = push;
    assign sb.dmem_req_valid = req_valid;
    assign sb.dmem_addr      = req_valid ? {entries[head].waddr, 2'b00} : '0;
    assign sb.dmem_wdata     = req_valid ? entries[head].data : '0;
    assign sb.dmem_wmask     = req_valid ? entries[head].wmask : '0;
    assign sb.sb_empty       = !req_valid;
    assign sb.misalign_err   = misalign_q;

    logic            lk_hit, lk_conflict;
    logic [XLEN-1:0] lk_data;
    logic [PW-1:0]   lk_idx;

    // Walk oldest to youngest from head; later matches overwrite, so the youngest decides.
    always_comb begin
        lk_hit      = 1'b0;
        lk_conflict = 1'b0;
        lk_data     = '0;
        lk_idx      = head;
        for (int k = 0; k < SB_DEPTH; k++) begin
            lk_idx = head + PW'(k);
            if (entries[lk_idx].valid && entries[lk_idx].waddr == word_addr(sb.ld_addr)
                && (entries[lk_idx].wmask & ld_need) != 4'b0000) begin
`ifdef SB_FWD_EN
                if ((entries[lk_idx].wmask & ld_need) == ld_need) begin
                    lk_hit      = 1'b1;
                    lk_conflict = 1'b0;
                    lk_data     = entries[lk_idx].data;
                end else begin
                    lk_hit      = 1'b0;
                    lk_conflict = 1'b1;
                    lk_data     = '0;
                end
`else
                lk_conflict = 1'b1;
`endif
            end
        end
    end

    assign sb.fwd_hit     = sb.ld_valid && lk_hit;
    assign sb.fwd_data    = sb.ld_valid ? lk_data : '0;
    assign sb.ld_conflict = sb.ld_valid && lk_conflict;

    logic unused_ok;
    assign unused_ok = ^{sb.st_funct3[2], sb.ld_funct3[2], ld_shifted_unused, ld_misaligned_unused};
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer; forwarding expectations follow SB_FWD_EN.
module tb_store_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    store_buffer_if #(.XLEN(32)) sb_if ();

    store_buffer #(.SB_DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .sb(sb_if)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        sb_if.st_valid  = v;
        sb_if.st_addr   = a;
        sb_if.st_data   = d;
        sb_if.st_funct3 = f;
    endtask

    task automatic set_ld(input logic v, input logic [31:0] a, input logic [2:0] f);
        sb_if.ld_valid  = v;
        sb_if.ld_addr   = a;
        sb_if.ld_funct3 = f;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_accept"},  sb_if.st_accept, 0);
        chk({tag, "_req_vld"}, sb_if.dmem_req_valid, 0);
        chk({tag, "_addr"},    sb_if.dmem_addr, 0);
        chk({tag, "_wdata"},   sb_if.dmem_wdata, 0);
        chk({tag, "_wmask"},   sb_if.dmem_wmask, 0);
        chk({tag, "_hit"},     sb_if.fwd_hit, 0);
        chk({tag, "_fdata"},   sb_if.fwd_data, 0);
        chk({tag, "_confl"},   sb_if.ld_conflict, 0);
        chk({tag, "_empty"},   sb_if.sb_empty, 1);
        chk({tag, "_misal"},   sb_if.misalign_err, 0);
    endtask

    // Fill four words while stalled, check the fifth is refused, then drain in order.
    task automatic fill_drain(input logic [31:0] base, input logic [31:0] dbase);
        sb_if.dmem_req_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_st(1'b1, base + 32'(4 * i), dbase + 32'(i), 3'd2);
            @(negedge clk);
            chk("fill_accept", sb_if.st_accept, 1);
            tick();
        end
        set_st(1'b1, base + 32'h40, 32'hFFFF_FFFF, 3'd2);
        @(negedge clk);
        chk("full_accept", sb_if.st_accept, 0);
        chk("full_hold_addr", sb_if.dmem_addr, base);
        tick();
        set_st(1'b0, 0, 0, 3'd2);
        sb_if.dmem_req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_vld", sb_if.dmem_req_valid, 1);
            chk("drain_addr", sb_if.dmem_addr, base + 32'(4 * i));
            chk("drain_data", sb_if.dmem_wdata, dbase + 32'(i));
            tick();
        end
        @(negedge clk);
        chk("drain_empty", sb_if.sb_empty, 1);
    endtask

    int          count_m;
    int          n;
    logic        acc_exp, pop_exp;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];

    initial begin
        set_st(1'b0, 0, 0, 3'd0);
        set_ld(1'b0, 0, 3'd0);
        sb_if.dmem_req_rdy = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset("rst");
        tick();

        // Single word store, drained the next cycle.
        set_st(1'b1, 32'h1000, 32'hDEAD_BEEF, 3'd2);
        @(negedge clk);
        chk("sw_accept", sb_if.st_accept, 1);
        chk("sw_empty_n0", sb_if.sb_empty, 1);
        tick();
        set_st(1'b0, 0, 0, 3'd2);
        @(negedge clk);
        chk("sw_req_vld", sb_if.dmem_req_valid, 1);
        chk("sw_addr", sb_if.dmem_addr, 32'h1000);
        chk("sw_mask", sb_if.dmem_wmask, 32'hF);
        chk("sw_data", sb_if.dmem_wdata, 32'hDEAD_BEEF);
        chk("sw_empty_n1", sb_if.sb_empty, 0);
        tick();
        @(negedge clk);
        chk("sw_empty_n2", sb_if.sb_empty, 1);
        tick();

        // Two fills so both pointers wrap.
        fill_drain(32'h0000_0100, 32'hA0A0_0000);
        tick();
        fill_drain(32'h0000_0180, 32'hB0B0_0000);
        tick();

        // Byte store then byte / word loads.
        sb_if.dmem_req_rdy = 1'b0;
        set_st(1'b1, 32'h2003, 32'h0000_00AB, 3'd0);
        set_ld(1'b1, 32'h2003, 3'd4);
        @(negedge clk);
        chk("sb_same_cyc_hit", sb_if.fwd_hit, 0);
        chk("sb_same_cyc_confl", sb_if.ld_conflict, 0);
        tick();
        set_st(1'b0, 0, 0, 3'd0);
        @(negedge clk);
        chk("sb_mask", sb_if.dmem_wmask, 32'h8);
        chk("sb_wdata", sb_if.dmem_wdata, 32'hABAB_ABAB);
`ifdef SB_FWD_EN
        chk("lbu_hit", sb_if.fwd_hit, 1);
        chk("lbu_byte", {24'h0, sb_if.fwd_data[31:24]}, 32'hAB);
        chk("lbu_confl", sb_if.ld_conflict, 0);
`else
        chk("lbu_hit", sb_if.fwd_hit, 0);
        chk("lbu_confl", sb_if.ld_conflict, 1);
`endif
        set_ld(1'b1, 32'h2000, 3'd2);
        @(posedge clk);
        @(negedge clk);
        chk("lw_confl", sb_if.ld_conflict, 1);
        chk("lw_hit", sb_if.fwd_hit, 0);
        set_ld(1'b0, 32'h2003, 3'd4);
        #1;
        chk("ld_idle_hit", sb_if.fwd_hit, 0);
        chk("ld_idle_confl", sb_if.ld_conflict, 0);
        tick();
        sb_if.dmem_req_rdy = 1'b1;
        tick();

        // Word then byte in the same word: youngest overlapping entry decides.
        sb_if.dmem_req_rdy = 1'b0;
        set_st(1'b1, 32'h3000, 32'h1111_1111, 3'd2);
        tick();
        set_st(1'b1, 32'h3001, 32'h0000_0022, 3'd0);
        tick();
        set_st(1'b0, 0, 0, 3'd0);
        set_ld(1'b1, 32'h3001, 3'd0);
        @(negedge clk);
`ifdef SB_FWD_EN
        chk("lb3001_hit", sb_if.fwd_hit, 1);
        chk("lb3001_data", sb_if.fwd_data, 32'h2222_2222);
`else
        chk("lb3001_confl", sb_if.ld_conflict, 1);
        chk("lb3001_fdata", sb_if.fwd_data, 0);
`endif
        tick();
        set_ld(1'b1, 32'h3000, 3'd0);
        @(negedge clk);
`ifdef SB_FWD_EN
        chk("lb3000_hit", sb_if.fwd_hit, 1);
        chk("lb3000_data", sb_if.fwd_data, 32'h1111_1111);
`else
        chk("lb3000_confl", sb_if.ld_conflict, 1);
`endif
        tick();
        set_ld(1'b1, 32'h3004, 3'd2);
        @(negedge clk);
        chk("other_word_hit", sb_if.fwd_hit, 0);
        chk("other_word_confl", sb_if.ld_conflict, 0);
        tick();
        // Pop of the word entry this cycle; the lookup still sees it.
        sb_if.dmem_req_rdy = 1'b1;
        set_ld(1'b1, 32'h3000, 3'd0);
        @(negedge clk);
`ifdef SB_FWD_EN
        chk("pop_cyc_hit", sb_if.fwd_hit, 1);
`else
        chk("pop_cyc_confl", sb_if.ld_conflict, 1);
`endif
        tick();
        @(negedge clk);
        chk("after_pop_hit", sb_if.fwd_hit, 0);
        chk("after_pop_confl", sb_if.ld_conflict, 0);
        tick();
        set_ld(1'b0, 0, 3'd0);
        @(negedge clk);
        chk("fwd_empty", sb_if.sb_empty, 1);
        tick();

        // Continuous push with rdy toggling; scoreboard tracks order and occupancy.
        count_m = 0;
        n = 0;
        for (int c = 0; c < 24; c++) begin
            sb_if.dmem_req_rdy = (c % 2 == 1);
            set_st(1'b1, 32'h5000 + 32'(4 * n), 32'hC0DE_0000 + 32'(n), 3'd2);
            @(negedge clk);
            acc_exp = (count_m != 4);
            pop_exp = (count_m != 0) && sb_if.dmem_req_rdy;
            chk("tog_accept", sb_if.st_accept, acc_exp);
            chk("tog_req_vld", sb_if.dmem_req_valid, count_m != 0);
            if (count_m != 0) begin
                chk("tog_addr", sb_if.dmem_addr, q_addr[0]);
                chk("tog_data", sb_if.dmem_wdata, q_data[0]);
            end
            if (pop_exp) begin
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
            if (acc_exp) begin
                q_addr.push_back(sb_if.st_addr);
                q_data.push_back(sb_if.st_data);
                n++;
            end
            count_m = count_m + int'(acc_exp) - int'(pop_exp);
            tick();
        end
        set_st(1'b0, 0, 0, 3'd2);
        sb_if.dmem_req_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (q_addr.size() != 0) begin
                chk("tail_addr", sb_if.dmem_addr, q_addr[0]);
                chk("tail_data", sb_if.dmem_wdata, q_data[0]);
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
            tick();
        end
        @(negedge clk);
        chk("tog_empty", sb_if.sb_empty, 1);
        tick();

        // Misaligned half store, sticky error, then reset while draining.
        sb_if.dmem_req_rdy = 1'b0;
        set_st(1'b1, 32'h4001, 32'h0000_1234, 3'd1);
        tick();
        set_st(1'b0, 0, 0, 3'd1);
        @(negedge clk);
        chk("sh_misal", sb_if.misalign_err, 1);
        chk("sh_mask", sb_if.dmem_wmask, 32'h6);
        chk("sh_data", sb_if.dmem_wdata, 32'h1234_1234);
        tick();
        sb_if.dmem_req_rdy = 1'b1;
        set_st(1'b1, 32'h4004, 32'h5555_5555, 3'd2);
        tick();
        @(negedge clk);
        chk("misal_sticky", sb_if.misalign_err, 1);
        chk("mid_drain_vld", sb_if.dmem_req_valid, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cyc_accept", sb_if.st_accept, 0);
        tick();
        @(negedge clk);
        chk_reset("rst_mid");
        tick();
        rst = 1'b0;
        set_st(1'b0, 0, 0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
